// File: rtl/vga_pkg.sv
// Shared constants, ASCII codes and types for the tile-screen character writer.
// Build option CHAR_WRITER_TAB_EN enables horizontal-tab handling in char_writer.
package vga_pkg;

  localparam int H_TILES    = 80;
  localparam int V_TILES    = 30;
  localparam int COL_WIDTH  = 7;
  localparam int ROW_WIDTH  = 5;
  localparam int DATA_WIDTH = 7;

  localparam logic [DATA_WIDTH-1:0] ASCII_BS    = 7'h08;
  localparam logic [DATA_WIDTH-1:0] ASCII_HT    = 7'h09;
  localparam logic [DATA_WIDTH-1:0] ASCII_LF    = 7'h0A;
  localparam logic [DATA_WIDTH-1:0] ASCII_FF    = 7'h0C;
  localparam logic [DATA_WIDTH-1:0] ASCII_CR    = 7'h0D;
  localparam logic [DATA_WIDTH-1:0] ASCII_SPACE = 7'h20;
  localparam logic [DATA_WIDTH-1:0] ASCII_DEL   = 7'h7F;

  typedef enum logic {IDLE, CLEAR} wr_state_e;

  typedef enum logic [2:0] {
    CUR_HOLD, CUR_INC, CUR_DEC, CUR_NL, CUR_CR, CUR_TAB, CUR_ZERO
  } cur_cmd_e;

  typedef struct packed {
    logic [ROW_WIDTH-1:0] row;
    logic [COL_WIDTH-1:0] col;
  } tile_pos_t;

  function automatic logic is_printable(input logic [DATA_WIDTH-1:0] c);
    return (c >= ASCII_SPACE) && (c != ASCII_DEL);
  endfunction

  // One tile back in row-major order; (0,0) wraps to the last tile.
  function automatic tile_pos_t prev_tile(input tile_pos_t p);
    tile_pos_t r;
    r = p;
    if (p.col == '0) begin
      r.col = COL_WIDTH'(H_TILES - 1);
      r.row = (p.row == '0) ? ROW_WIDTH'(V_TILES - 1) : p.row - 1'b1;
    end else begin
      r.col = p.col - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tile_cursor.sv
// Column/row register pair stepping across the 80x30 grid with explicit wrap at the
// last column/row; used for the text cursor and for the clear scan.
module tile_cursor import vga_pkg::*; (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  cur_cmd_e             cmd_i,
  output logic [COL_WIDTH-1:0] col_o,
  output logic [ROW_WIDTH-1:0] row_o
);

  logic [COL_WIDTH-1:0] col_q, col_d;
  logic [ROW_WIDTH-1:0] row_q, row_d;
  logic [ROW_WIDTH-1:0] row_inc;
  logic [COL_WIDTH:0]   tab_sum;
  tile_pos_t            prev;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    row_inc = (row_q == ROW_WIDTH'(V_TILES - 1)) ? '0 : row_q + 1'b1;
    tab_sum = {1'b0, col_q & ~COL_WIDTH'(7)} + (COL_WIDTH + 1)'(8);
    prev    = prev_tile('{row: row_q, col: col_q});
    case (cmd_i)
      CUR_INC: begin
        if (col_q == COL_WIDTH'(H_TILES - 1)) begin
          col_d = '0;
          row_d = row_inc;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      CUR_DEC: begin
        col_d = prev.col;
        row_d = prev.row;
      end
      CUR_NL: begin
        col_d = '0;
        row_d = row_inc;
      end
      CUR_CR: col_d = '0;
      // Next multiple of 8; stepping past the last tab stop behaves as a newline.
      CUR_TAB: begin
        if (tab_sum >= (COL_WIDTH + 1)'(H_TILES)) begin
          col_d = '0;
          row_d = row_inc;
        end else begin
          col_d = tab_sum[COL_WIDTH-1:0];
        end
      end
      CUR_ZERO: begin
        col_d = '0;
        row_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/char_writer.sv
// Character stream to tile-write converter with text cursor and full-screen clear.
// Build option CHAR_WRITER_TAB_EN: HT advances to the next 8-column tab stop.
module char_writer import vga_pkg::*; (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  char_valid_i,
  input  logic [DATA_WIDTH-1:0] char_i,
  output logic                  char_ready_o,
  input  logic                  clear_i,
  output logic                  wr_en_o,
  output logic [COL_WIDTH-1:0]  col_w_o,
  output logic [ROW_WIDTH-1:0]  row_w_o,
  output logic [DATA_WIDTH-1:0] din_o,
  output logic [COL_WIDTH-1:0]  cursor_col_o,
  output logic [ROW_WIDTH-1:0]  cursor_row_o,
  output logic                  busy_o
);

  wr_state_e             state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [COL_WIDTH-1:0]  col_w_q, col_w_d;
  logic [ROW_WIDTH-1:0]  row_w_q, row_w_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  cur_cmd_e              cur_cmd, scan_cmd;
  logic [COL_WIDTH-1:0]  scan_col;
  logic [ROW_WIDTH-1:0]  scan_row;
  tile_pos_t             bs_pos;

  tile_cursor u_cursor (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .cmd_i  (cur_cmd),
    .col_o  (cursor_col_o),
    .row_o  (cursor_row_o)
  );

  tile_cursor u_scan (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .cmd_i  (scan_cmd),
    .col_o  (scan_col),
    .row_o  (scan_row)
  );

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    col_w_d      = col_w_q;
    row_w_d      = row_w_q;
    din_d        = din_q;
    cur_cmd      = CUR_HOLD;
    scan_cmd     = CUR_HOLD;
    char_ready_o = (state_q == IDLE);
    accept       = char_valid_i && char_ready_o;
    bs_pos       = prev_tile('{row: cursor_row_o, col: cursor_col_o});
    case (state_q)
      IDLE: begin
        // A clear request takes priority; a character accepted on the same edge is dropped.
        if (clear_i || (accept && char_i == ASCII_FF)) begin
          state_d  = CLEAR;
          scan_cmd = CUR_ZERO;
        end else if (accept) begin
          if (is_printable(char_i)) begin
            wr_en_d = 1'b1;
            col_w_d = cursor_col_o;
            row_w_d = cursor_row_o;
            din_d   = char_i;
            cur_cmd = CUR_INC;
          end else begin
            case (char_i)
              ASCII_CR: cur_cmd = CUR_CR;
              ASCII_LF: cur_cmd = CUR_NL;
              ASCII_BS: begin
                if (cursor_col_o != '0 || cursor_row_o != '0) begin
                  cur_cmd = CUR_DEC;
                  wr_en_d = 1'b1;
                  col_w_d = bs_pos.col;
                  row_w_d = bs_pos.row;
                  din_d   = ASCII_SPACE;
                end
              end
`ifdef CHAR_WRITER_TAB_EN
              ASCII_HT: cur_cmd = CUR_TAB;
`endif
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        wr_en_d  = 1'b1;
        col_w_d  = scan_col;
        row_w_d  = scan_row;
        din_d    = '0;
        scan_cmd = CUR_INC;
        if (scan_col == COL_WIDTH'(H_TILES - 1) && scan_row == ROW_WIDTH'(V_TILES - 1)) begin
          state_d = IDLE;
          cur_cmd = CUR_ZERO;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      col_w_q <= '0;
      row_w_q <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      col_w_q <= col_w_d;
      row_w_q <= row_w_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
    end
  end

  assign wr_en_o = wr_en_q;
  assign col_w_o = col_w_q;
  assign row_w_o = row_w_q;
  assign din_o   = din_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_char_writer.sv
// Bench for char_writer: table of single-character vectors, hand sequences for wraps,
// clear and reset-abort; all tile writes are checked through an expected-write queue.
module tb_char_writer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       char_valid = 1'b0;
  logic [6:0] ch = '0;
  logic       clear = 1'b0;
  logic       char_ready, wr_en, busy;
  logic [6:0] col_w, din, cur_col;
  logic [4:0] row_w, cur_row;

  char_writer dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .char_valid_i (char_valid),
    .char_i       (ch),
    .char_ready_o (char_ready),
    .clear_i      (clear),
    .wr_en_o      (wr_en),
    .col_w_o      (col_w),
    .row_w_o      (row_w),
    .din_o        (din),
    .cursor_col_o (cur_col),
    .cursor_row_o (cur_row),
    .busy_o       (busy)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;
  int sb[$];
  int mon_e;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int pk(input int c, input int r, input int d);
    return (c << 16) | (r << 8) | d;
  endfunction

  always @(negedge clk) begin
    if (rstn && wr_en) begin
      n_wr++;
      if (sb.size() == 0) begin
        chk("unexpected_write", pk(int'(col_w), int'(row_w), int'(din)), -1);
      end else begin
        mon_e = sb.pop_front();
        chk("write", pk(int'(col_w), int'(row_w), int'(din)), mon_e);
      end
    end
  end

  task automatic send(input logic [6:0] c, input bit wr, input int wc, input int wrow,
                      input int wd, input int ec, input int er, input string nm);
    @(negedge clk);
    chk({nm, "_ready"}, int'(char_ready), 1);
    char_valid = 1'b1;
    ch = c;
    if (wr) sb.push_back(pk(wc, wrow, wd));
    @(negedge clk);
    char_valid = 1'b0;
    #1;
    chk({nm, "_write_seen"}, sb.size(), 0);
    sb.delete();
    chk({nm, "_cursor"}, pk(int'(cur_col), int'(cur_row), 0), pk(ec, er, 0));
  endtask

  task automatic print_run(input int n, input int row);
    logic [6:0] c;
    for (int i = 0; i < n; i++) begin
      c = 7'h61 + 7'(i % 26);
      send(c, 1'b1, i, row, int'(c), i + 1, row, "print_run");
    end
  endtask

  typedef struct {
    logic [6:0] c;
    bit         wr;
    int         wc, wrow, wd, ec, er;
    string      nm;
  } vec_t;

  vec_t tbl[11];
  int   base, bad, w0;

  initial begin
    tbl[0]  = '{7'h41, 1'b1, 0, 0, 'h41, 1, 0, "print_A"};
    tbl[1]  = '{7'h42, 1'b1, 1, 0, 'h42, 2, 0, "print_B"};
    tbl[2]  = '{7'h08, 1'b1, 1, 0, 'h20, 1, 0, "bs_1"};
    tbl[3]  = '{7'h08, 1'b1, 0, 0, 'h20, 0, 0, "bs_2"};
    tbl[4]  = '{7'h08, 1'b0, 0, 0, 0,    0, 0, "bs_origin"};
    tbl[5]  = '{7'h7F, 1'b0, 0, 0, 0,    0, 0, "del_ignored"};
    tbl[6]  = '{7'h01, 1'b0, 0, 0, 0,    0, 0, "ctrl_ignored"};
    tbl[7]  = '{7'h78, 1'b1, 0, 0, 'h78, 1, 0, "print_x"};
    tbl[8]  = '{7'h0D, 1'b0, 0, 0, 0,    0, 0, "cr"};
    tbl[9]  = '{7'h0A, 1'b0, 0, 0, 0,    0, 1, "lf_1"};
    tbl[10] = '{7'h0A, 1'b0, 0, 0, 0,    0, 2, "lf_2"};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", pk(int'(col_w), int'(row_w), int'(din)), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cursor", pk(int'(cur_col), int'(cur_row), 0), 0);
    chk("rst_ready", int'(char_ready), 1);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i])
      send(tbl[i].c, tbl[i].wr, tbl[i].wc, tbl[i].wrow, tbl[i].wd, tbl[i].ec, tbl[i].er, tbl[i].nm);

    // (17,3), then CR/LF
    send(7'h0A, 1'b0, 0, 0, 0, 0, 3, "lf_3");
    print_run(17, 3);
    send(7'h0D, 1'b0, 0, 0, 0, 0, 3, "cr_17_3");
    send(7'h0A, 1'b0, 0, 0, 0, 0, 4, "lf_after_cr");
    send(7'h0A, 1'b0, 0, 0, 0, 0, 5, "lf_5");
    send(7'h08, 1'b1, 79, 4, 'h20, 79, 4, "bs_row_back");
    send(7'h0A, 1'b0, 0, 0, 0, 0, 5, "lf_from_79");
    for (int r = 6; r < 30; r++) send(7'h0A, 1'b0, 0, 0, 0, 0, r, "lf_walk");
    send(7'h0A, 1'b0, 0, 0, 0, 0, 0, "lf_row_wrap");

    // last tile write and full wrap to origin
    for (int r = 1; r < 30; r++) send(7'h0A, 1'b0, 0, 0, 0, 0, r, "lf_walk2");
    print_run(79, 29);
    send(7'h5A, 1'b1, 79, 29, 'h5A, 0, 0, "print_Z_wrap");

    print_run(77, 0);
`ifdef CHAR_WRITER_TAB_EN
    send(7'h09, 1'b0, 0, 0, 0, 0, 1, "tab_wrap");
    send(7'h09, 1'b0, 0, 0, 0, 8, 1, "tab_stop");
`else
    send(7'h09, 1'b0, 0, 0, 0, 77, 0, "tab_ignored");
    send(7'h09, 1'b0, 0, 0, 0, 77, 0, "tab_ignored2");
`endif

    // clear_i together with a valid char: clear wins, char dropped
    @(negedge clk);
    chk("clear_ready_before", int'(char_ready), 1);
    base = n_wr;
    clear = 1'b1;
    char_valid = 1'b1;
    ch = 7'h51;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) sb.push_back(pk(c, r, 0));
    @(negedge clk);
    clear = 1'b0;
    char_valid = 1'b0;
    #1;
    chk("clear_busy_high", int'(busy), 1);
    chk("clear_ready_low", int'(char_ready), 0);
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
      if (busy !== 1'b1 || char_ready !== 1'b0) bad++;
    end
    chk("clear_all_written", sb.size(), 0);
    sb.delete();
    chk("clear_busy_ready_held", bad, 0);
    chk("clear_write_count", n_wr - base, 2400);
    @(negedge clk);
    #1;
    chk("clear_done_ready", int'(char_ready), 1);
    chk("clear_done_busy", int'(busy), 0);
    chk("clear_done_cursor", pk(int'(cur_col), int'(cur_row), 0), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("clear_char_dropped", n_wr - base, 2400);

    // FF starts a clear; reset at write 1000 aborts it
    send(7'h6B, 1'b1, 0, 0, 'h6B, 1, 0, "print_k");
    @(negedge clk);
    char_valid = 1'b1;
    ch = 7'h0C;
    base = n_wr;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) sb.push_back(pk(c, r, 0));
    @(negedge clk);
    char_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (n_wr - base >= 1000) break;
    end
    chk("ff_clear_reached_1000", n_wr - base, 1000);
    chk("ff_clear_cursor_held", pk(int'(cur_col), int'(cur_row), 0), pk(1, 0, 0));
    rstn = 1'b0;
    #1;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(char_ready), 1);
    chk("abort_cursor", pk(int'(cur_col), int'(cur_row), 0), 0);
    chk("abort_outputs", pk(int'(col_w), int'(row_w), int'(din)), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    w0 = n_wr;
    repeat (30) @(negedge clk);
    #1;
    chk("abort_no_more_writes", n_wr - w0, 0);
    chk("abort_idle_ready", int'(char_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
